// File: rtl/store_narrow_if.sv
// Request/memory-port bundle for store_narrow_unit.
// Carries err only when STORE_NARROW_MISALIGN_TRAP_EN is defined.
interface store_narrow_if #(
  parameter int OFFSET_WIDTH = 6
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_byte;
  logic [15:0]             base;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [15:0]             src_data;
  logic                    done;
  logic [15:0]             mem_address;
  logic [15:0]             mem_wdata;
  logic                    mem_write;
  logic [1:0]              mem_byte_enable;
  logic                    mem_resp;
`ifdef STORE_NARROW_MISALIGN_TRAP_EN
  logic                    err;

  modport master (
    output req_valid, req_byte, base, offset, src_data, mem_resp,
    input  req_ready, done, mem_address, mem_wdata, mem_write, mem_byte_enable, err
  );
  modport slave (
    input  req_valid, req_byte, base, offset, src_data, mem_resp,
    output req_ready, done, mem_address, mem_wdata, mem_write, mem_byte_enable, err
  );
`else
  modport master (
    output req_valid, req_byte, base, offset, src_data, mem_resp,
    input  req_ready, done, mem_address, mem_wdata, mem_write, mem_byte_enable
  );
  modport slave (
    input  req_valid, req_byte, base, offset, src_data, mem_resp,
    output req_ready, done, mem_address, mem_wdata, mem_write, mem_byte_enable
  );
`endif
endinterface

// File: rtl/store_narrow_unit.sv
// LC-3b store path: effective address, lane narrowing, byte enables and mem_write/mem_resp handshake.
// Optional STORE_NARROW_MISALIGN_TRAP_EN: misaligned word stores trap through err instead of writing.
module store_narrow_unit #(
  parameter int OFFSET_WIDTH = 6,
  parameter bit BYTE_SCALE   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  store_narrow_if.slave bus
);
  // state | meaning
  // IDLE  | ready, accept on req_valid
  // WRITE | mem_write held until mem_resp
  // DONE  | one-cycle done (and err) pulse
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state_q, state_d;

  logic [15:0] off_sext, off_scaled, ea;
  logic [15:0] addr_d, wdata_d;
  logic [1:0]  be_d;
  logic [15:0] addr_q, wdata_q;
  logic [1:0]  be_q;
  logic        accept, trap;

  assign off_sext   = {{(16-OFFSET_WIDTH){bus.offset[OFFSET_WIDTH-1]}}, bus.offset};
  assign off_scaled = (!bus.req_byte || (BYTE_SCALE != 1'b0)) ? {off_sext[14:0], 1'b0} : off_sext;
  assign ea         = bus.base + off_scaled;
  assign accept     = (state_q == IDLE) && bus.req_valid;

  // Word stores always drive an even address; a misaligned word EA is rounded down.
  always_comb begin
    wdata_d = bus.req_byte ? {2{bus.src_data[7:0]}} : bus.src_data;
    be_d    = bus.req_byte ? (ea[0] ? 2'b10 : 2'b01) : 2'b11;
    addr_d  = {ea[15:1], bus.req_byte & ea[0]};
  end

`ifdef STORE_NARROW_MISALIGN_TRAP_EN
  logic err_q;

  assign trap = accept && !bus.req_byte && ea[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (accept)
      err_q <= trap;
  end

  assign bus.err = (state_q == DONE) && err_q;
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = trap ? DONE : WRITE;
      WRITE:   if (bus.mem_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A trapped store leaves the memory-side registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
    end else if (accept && !trap) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.mem_write       = (state_q == WRITE);
  assign bus.done            = (state_q == DONE);
  assign bus.mem_address     = addr_q;
  assign bus.mem_wdata       = wdata_q;
  assign bus.mem_byte_enable = be_q;
endmodule
